// File: rtl/nsum_pkg.sv
// Shared types and constants for the NSUM arbiter slice.
package nsum_pkg;
  localparam int N_W   = 3;
  localparam int SUM_W = 8;
  localparam logic [SUM_W-1:0] ERR_SUM = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;
endpackage

// File: rtl/nsum_arbiter_if.sv
// Requester / engine / response bundle for nsum_arbiter; master = arbiter side.
interface nsum_arbiter_if #(parameter int NUM_REQ = 4);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                     req_valid;
  logic [NUM_REQ-1:0]                     req_ready;
  logic [NUM_REQ-1:0][nsum_pkg::N_W-1:0]  req_n;
  logic [nsum_pkg::N_W-1:0]               eng_N;
  logic                                   eng_N_valid;
  logic                                   eng_sum_valid;
  logic [nsum_pkg::SUM_W-1:0]             eng_sum;
  logic                                   resp_valid;
  logic                                   resp_ready;
  logic [ID_W-1:0]                        resp_id;
  logic [nsum_pkg::SUM_W-1:0]             resp_sum;
  logic                                   resp_err;
  logic                                   busy;

  modport master (
    input  req_valid, req_n, eng_sum_valid, eng_sum, resp_ready,
    output req_ready, eng_N, eng_N_valid, resp_valid, resp_id, resp_sum, resp_err, busy
  );

  modport slave (
    output req_valid, req_n, eng_sum_valid, eng_sum, resp_ready,
    input  req_ready, eng_N, eng_N_valid, resp_valid, resp_id, resp_sum, resp_err, busy
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin search: first valid requester at or above rr_ptr, with wrap.
module rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    grant,
  output logic               found
);
  always_comb begin
    logic [ID_W-1:0] idx;
    idx   = '0;
    grant = '0;
    found = 1'b0;
    // Walk offsets from farthest to nearest so the nearest hit overwrites.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/nsum_arbiter.sv
// Round-robin sequencer sharing one NSUM engine among NUM_REQ requesters.
// Define NSUM_ARB_TIMEOUT_EN to add a WAIT watchdog reporting resp_err.
module nsum_arbiter import nsum_pkg::*; #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic            clk,
  input logic            reset,
  nsum_arbiter_if.master bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_e       state, state_nx;
  logic [ID_W-1:0]  rr_ptr, cur_id, grant, resp_id_q;
  logic [N_W-1:0]   cur_n;
  logic [SUM_W-1:0] resp_sum_q, sum_nx;
  logic             found, sv_q, rise, done;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .found     (found)
  );

  // Only a fresh low-to-high edge counts; sv_q is primed high in ISSUE.
  assign rise = bus.eng_sum_valid & ~sv_q;

`ifdef NSUM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout, resp_err_q;

  assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign done    = rise | timeout;
  assign sum_nx  = rise ? bus.eng_sum : ERR_SUM;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt   <= '0;
      resp_err_q <= 1'b0;
    end else begin
      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      // A rise in the timeout cycle wins: no error.
      if (state == WAIT && done) resp_err_q <= ~rise;
    end
  end

  assign bus.resp_err = resp_err_q;
`else
  assign done         = rise;
  assign sum_nx       = bus.eng_sum;
  assign bus.resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found)          state_nx = ISSUE;
      ISSUE:                       state_nx = WAIT;
      WAIT:    if (done)           state_nx = RESP;
      RESP:    if (bus.resp_ready) state_nx = IDLE;
      default:                     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= '0;
      cur_id     <= '0;
      cur_n      <= '0;
      sv_q       <= 1'b0;
      resp_id_q  <= '0;
      resp_sum_q <= '0;
    end else begin
      sv_q <= (state == ISSUE) ? 1'b1 : bus.eng_sum_valid;
      if (state == IDLE && found) begin
        cur_id <= grant;
        cur_n  <= bus.req_n[grant];
      end
      if (state == WAIT && done) begin
        resp_id_q  <= cur_id;
        resp_sum_q <= sum_nx;
      end
      if (state == RESP && bus.resp_ready)
        rr_ptr <= ID_W'((int'(cur_id) + 1) % NUM_REQ);
    end
  end

  // Grant strobe is combinational in IDLE, masked while reset is held.
  always_comb begin
    bus.req_ready = '0;
    if (reset && state == IDLE && found) bus.req_ready[grant] = 1'b1;
  end

  assign bus.eng_N       = cur_n;
  assign bus.eng_N_valid = (state == ISSUE);
  assign bus.resp_valid  = (state == RESP);
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_sum    = resp_sum_q;
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_nsum_arbiter.sv
// Directed + randomized bench for nsum_arbiter with an N*N engine stub.
module tb_nsum_arbiter;
  localparam int NR = 4;
  localparam int TO = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nsum_arbiter_if #(.NUM_REQ(NR)) bus ();
  nsum_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Engine stub: sum_valid rises 5 cycles after N_valid and holds until the next job.
  // stale_mode keeps the old level high a few cycles into the new job; mute_mode never answers.
  bit         stale_mode = 1'b0;
  bit         mute_mode  = 1'b0;
  logic [1:0] stub_cnt;
  logic       stub_pend;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.eng_sum_valid <= 1'b0;
      bus.eng_sum       <= '0;
      stub_cnt          <= '0;
      stub_pend         <= 1'b0;
    end else if (bus.eng_N_valid) begin
      bus.eng_sum <= 8'({5'd0, bus.eng_N} * {5'd0, bus.eng_N});
      stub_pend   <= !mute_mode;
      stub_cnt    <= 2'd3;
      if (!stale_mode) bus.eng_sum_valid <= 1'b0;
    end else if (stub_pend) begin
      if (stub_cnt == 2'd0) begin
        bus.eng_sum_valid <= 1'b1;
        stub_pend         <= 1'b0;
      end else begin
        if (stub_cnt == 2'd1) bus.eng_sum_valid <= 1'b0;
        stub_cnt <= stub_cnt - 2'd1;
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int ptr    = 0;   // reference round-robin pointer

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; ends at a negedge right after the handshake.
  task automatic run_job(input logic [NR-1:0] rv, input logic [NR-1:0][2:0] rn,
                         input int hold, input bit stale, input bit mute, output int gid);
    int g, lat, exp_lat, exp_n;
    logic [7:0] exp_sum;
    g = -1;
    for (int k = 0; k < NR; k++)
      if (g < 0 && rv[(ptr + k) % NR]) g = (ptr + k) % NR;
    gid     = g;
    exp_n   = int'(rn[g]);
    exp_sum = mute ? 8'hFF : 8'(exp_n * exp_n);
    exp_lat = mute ? TO + 2 : 7;
    stale_mode = stale;
    mute_mode  = mute;
    bus.req_valid  = rv;
    bus.req_n      = rn;
    bus.resp_ready = 1'b0;
    #1;
    check("grant", 32'(bus.req_ready), 32'(1 << g));
    check("busy_idle", 32'(bus.busy), 0);
    @(negedge clk);
    check("issue_pulse", 32'(bus.eng_N_valid), 1);
    check("eng_n", 32'(bus.eng_N), exp_n);
    check("no_grant_busy", 32'(bus.req_ready), 0);
    bus.req_valid = NR'($urandom);
    bus.req_n     = 12'($urandom);
    lat = 1;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid && lat < 60);
    check("latency", lat, exp_lat);
    check("resp_id", 32'(bus.resp_id), g);
    check("resp_sum", 32'(bus.resp_sum), 32'(exp_sum));
    check("resp_err", 32'(bus.resp_err), 32'(mute));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.req_valid = NR'($urandom_range(1, (1 << NR) - 1));
      #1;
      check("hold_valid", 32'(bus.resp_valid), 1);
      check("hold_id", 32'(bus.resp_id), g);
      check("hold_sum", 32'(bus.resp_sum), 32'(exp_sum));
      check("hold_no_grant", 32'(bus.req_ready), 0);
    end
    bus.resp_ready = 1'b1;
    bus.req_valid  = '0;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("resp_drop", 32'(bus.resp_valid), 0);
    check("idle_after", 32'(bus.busy), 0);
    ptr = (g + 1) % NR;
  endtask

  initial begin
    int gid;
    logic [NR-1:0][2:0] rn;
    bus.req_valid  = 4'b1111;
    bus.req_n      = '0;
    bus.resp_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_eng_n", 32'(bus.eng_N), 0);
    check("rst_eng_v", 32'(bus.eng_N_valid), 0);
    check("rst_resp_v", 32'(bus.resp_valid), 0);
    check("rst_resp_id", 32'(bus.resp_id), 0);
    check("rst_resp_sum", 32'(bus.resp_sum), 0);
    check("rst_resp_err", 32'(bus.resp_err), 0);
    check("rst_busy", 32'(bus.busy), 0);
    repeat (2) @(negedge clk);
    bus.req_valid = '0;
    reset = 1'b1;
    @(negedge clk);

    // Single request from id 2 with N=5.
    rn = '0; rn[2] = 3'd5;
    run_job(4'b0100, rn, 0, 1'b0, 1'b0, gid);
    check("single_id", gid, 2);

    // Reset asserted while waiting on the engine.
    rn = '0; rn[1] = 3'd3;
    bus.req_valid = 4'b0010;
    bus.req_n     = rn;
    repeat (3) @(negedge clk);
    bus.req_valid = 4'b1111;
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_resp_v", 32'(bus.resp_valid), 0);
    check("mid_rst_req_ready", 32'(bus.req_ready), 0);
    check("mid_rst_eng_n", 32'(bus.eng_N), 0);
    check("mid_rst_resp_sum", 32'(bus.resp_sum), 0);
    @(negedge clk);
    bus.req_valid = '0;
    reset = 1'b1;
    ptr = 0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_resp_v", 32'(bus.resp_valid), 0);
      check("post_rst_busy", 32'(bus.busy), 0);
    end

    // Round robin with everyone requesting: 0,1,2,3 then back to 0.
    rn = {3'd4, 3'd3, 3'd2, 3'd1};
    for (int i = 0; i < 5; i++) begin
      run_job(4'b1111, rn, 0, 1'b0, 1'b0, gid);
      check("rr_order", gid, i % NR);
    end

    // Backpressure: consumer stalls for 10 cycles.
    rn = 12'($urandom);
    run_job(4'b1000, rn, 10, 1'b0, 1'b0, gid);

    // Stale sum_valid level carried into the next job.
    rn = 12'($urandom);
    run_job(4'b0001, rn, 0, 1'b1, 1'b0, gid);

`ifdef NSUM_ARB_TIMEOUT_EN
    rn = 12'($urandom);
    run_job(4'b0100, rn, 2, 1'b0, 1'b1, gid);
    rn = 12'($urandom);
    run_job(4'b0100, rn, 0, 1'b0, 1'b0, gid);
`endif

    // Random traffic, including N=0 and stale-level jobs.
    repeat (25) begin
      rn = 12'($urandom);
      if ($urandom_range(0, 3) == 0) rn[$urandom_range(0, NR - 1)] = 3'd0;
      run_job(NR'($urandom_range(1, (1 << NR) - 1)), rn,
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, gid);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
